mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port byte-wide memory.
// States: IDLE wait for req | ISSUE one memory cycle | WAIT read latency | DONE ack + rdata
module mem_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [7:0]        p0_wdata,
  output logic              p0_ack,
  output logic [7:0]        p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [7:0]        p1_wdata,
  output logic              p1_ack,
  output logic [7:0]        p1_rdata,
  output logic              mem_ena,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addra,
  output logic [7:0]        mem_dina,
  input  logic [7:0]        mem_douta,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT spans RD_LATENCY-1 cycles: load RD_LATENCY-2 and leave when the count hits zero.
  localparam logic [1:0] WAIT_LOAD = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dina_q, dina_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              ena_q, ena_d;
  logic              wea_q, wea_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [7:0]        rdata0_q, rdata0_d;
  logic [7:0]        rdata1_q, rdata1_d;
  logic              grant;
  logic              finish_rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dina_q   <= '0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      ena_q    <= 1'b0;
      wea_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dina_q   <= dina_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      ena_q    <= ena_d;
      wea_q    <= wea_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    dina_d    = dina_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ena_d     = 1'b0;
    wea_d     = 1'b0;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    finish_rd = 1'b0;
    grant     = (p0_req && p1_req) ? ~last_q : p1_req;

    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          state_d = ISSUE;
          owner_d = grant;
          we_d    = grant ? p1_we    : p0_we;
          addr_d  = grant ? p1_addr  : p0_addr;
          dina_d  = grant ? p1_wdata : p0_wdata;
          ena_d   = 1'b1;
          wea_d   = we_d;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else if (RD_LATENCY == 1) begin
          state_d   = DONE;
          finish_rd = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d   = DONE;
          finish_rd = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase

    // Acks are registered so they line up with the DONE state itself.
    if (state_d == DONE) begin
      ack0_d = ~owner_q;
      ack1_d = owner_q;
    end
    if (finish_rd) begin
      if (owner_q) rdata1_d = mem_douta;
      else         rdata0_d = mem_douta;
    end
  end

  assign mem_ena   = ena_q;
  assign mem_wea   = wea_q;
  assign mem_addra = addr_q;
  assign mem_dina  = dina_q;
  assign p0_ack    = ack0_q;
  assign p1_ack    = ack1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign busy      = (state_q != IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (read latency 3 and 1) share the requester inputs
// and are compared every cycle against a transfer-level model, plus directed scenarios.
module tb_mem_arbiter;

  localparam int LAT_A = 3;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p1_addr = '0;
  logic [7:0]  p0_wdata = '0, p1_wdata = '0;

  logic        a_p0_ack, a_p1_ack, a_ena, a_wea, a_busy, a_owner;
  logic [7:0]  a_p0_rd, a_p1_rd, a_din, a_dout;
  logic [15:0] a_addr;
  logic        b_p0_ack, b_p1_ack, b_ena, b_wea, b_busy, b_owner;
  logic [7:0]  b_p0_rd, b_p1_rd, b_din, b_dout;
  logic [15:0] b_addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.RD_LATENCY(LAT_A), .ADDR_W(16)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(a_p0_ack), .p0_rdata(a_p0_rd),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(a_p1_ack), .p1_rdata(a_p1_rd),
    .mem_ena(a_ena), .mem_wea(a_wea), .mem_addra(a_addr), .mem_dina(a_din),
    .mem_douta(a_dout), .busy(a_busy), .owner(a_owner)
  );

  mem_arbiter #(.RD_LATENCY(LAT_B), .ADDR_W(16)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rd),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rd),
    .mem_ena(b_ena), .mem_wea(b_wea), .mem_addra(b_addr), .mem_dina(b_din),
    .mem_douta(b_dout), .busy(b_busy), .owner(b_owner)
  );

  // Power-on memory contents: a fixed pattern, with 0x3C at 0xFFFC.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return (a == 16'hFFFC) ? 8'h3C : (a[7:0] ^ 8'hA7);
  endfunction

  // Memory devices: sampled mid-cycle, so data is ready at every capture edge.
  logic [7:0] dmem_a [65536];
  bit         dwr_a  [65536];
  logic [7:0] dmem_b [65536];
  bit         dwr_b  [65536];

  always @(negedge clk) begin
    if (a_ena && a_wea) begin
      dmem_a[a_addr] <= a_din;
      dwr_a[a_addr]  <= 1'b1;
    end
    a_dout <= dwr_a[a_addr] ? dmem_a[a_addr] : init_val(a_addr);
  end

  always @(negedge clk) begin
    if (b_ena && b_wea) begin
      dmem_b[b_addr] <= b_din;
      dwr_b[b_addr]  <= 1'b1;
    end
    b_dout <= dwr_b[b_addr] ? dmem_b[b_addr] : init_val(b_addr);
  end

  // Transfer-level reference: one in-flight transfer, age counted in edges since grant.
  bit          m_act [2], m_port [2], m_we [2], m_last [2], m_owner [2];
  int          m_age [2], m_done [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_wd [2], m_rd0 [2], m_rd1 [2];
  logic [7:0]  rmem [2][65536];
  bit          rwr  [2][65536];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_port[k] = 0; m_we[k] = 0; m_last[k] = 1; m_owner[k] = 0;
      m_age[k] = 0; m_done[k] = 0; m_addr[k] = '0; m_wd[k] = '0;
      m_rd0[k] = '0; m_rd1[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    bit w;
    logic [7:0] v;
    if (!m_act[k]) begin
      if (p0_req || p1_req) begin
        w = (p0_req && p1_req) ? !m_last[k] : p1_req;
        m_act[k] = 1; m_age[k] = 1; m_port[k] = w; m_owner[k] = w;
        m_we[k]   = w ? p1_we : p0_we;
        m_addr[k] = w ? p1_addr : p0_addr;
        m_wd[k]   = w ? p1_wdata : p0_wdata;
        m_done[k] = m_we[k] ? 2 : lat_of(k) + 1;
        if (m_we[k]) begin
          rmem[k][m_addr[k]] = m_wd[k];
          rwr[k][m_addr[k]]  = 1;
        end
      end
    end else begin
      m_age[k]++;
      if (m_age[k] == m_done[k]) begin
        if (!m_we[k]) begin
          v = rwr[k][m_addr[k]] ? rmem[k][m_addr[k]] : init_val(m_addr[k]);
          if (m_port[k]) m_rd1[k] = v;
          else           m_rd0[k] = v;
        end
        m_last[k] = m_port[k];
      end else if (m_age[k] > m_done[k]) begin
        m_act[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int k, input string nm,
                            input logic ena, input logic wea, input logic [15:0] addr,
                            input logic [7:0] din, input logic ack0, input logic ack1,
                            input logic [7:0] rd0, input logic [7:0] rd1,
                            input logic bsy, input logic own);
    bit issue, done;
    issue = m_act[k] && (m_age[k] == 1);
    done  = m_act[k] && (m_age[k] == m_done[k]);
    chk({nm, ".mem_ena"},   32'(ena),  32'(issue));
    chk({nm, ".mem_wea"},   32'(wea),  32'(issue && m_we[k]));
    chk({nm, ".mem_addra"}, 32'(addr), 32'(m_addr[k]));
    chk({nm, ".mem_dina"},  32'(din),  32'(m_wd[k]));
    chk({nm, ".p0_ack"},    32'(ack0), 32'(done && !m_port[k]));
    chk({nm, ".p1_ack"},    32'(ack1), 32'(done && m_port[k]));
    chk({nm, ".ack_excl"},  32'(ack0 && ack1), 32'(0));
    chk({nm, ".p0_rdata"},  32'(rd0),  32'(m_rd0[k]));
    chk({nm, ".p1_rdata"},  32'(rd1),  32'(m_rd1[k]));
    chk({nm, ".busy"},      32'(bsy),  32'(m_act[k]));
    chk({nm, ".owner"},     32'(own),  32'(m_owner[k]));
  endtask

  task automatic check_all();
    check_inst(0, "L3", a_ena, a_wea, a_addr, a_din, a_p0_ack, a_p1_ack, a_p0_rd, a_p1_rd, a_busy, a_owner);
    check_inst(1, "L1", b_ena, b_wea, b_addr, b_din, b_p0_ack, b_p1_ack, b_p0_rd, b_p1_rd, b_busy, b_owner);
  endtask

  // Inputs are set at a falling edge before calling; outputs checked at the next falling edge.
  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_assert();
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
  endtask

  task automatic reset_release();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [15:0] addr, input logic [7:0] wd);
    if (port == 0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wd;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wd;
    end
  endtask

  int  ord_a [$];
  int  ord_b [$];
  int  exp_ord [4];
  int  acks_a, acks_b;

  initial begin
    exp_ord = '{0, 1, 0, 1};
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    chk("reset.last_served_winner_pending", 32'(m_last[0]), 32'(1));
    resetn = 1'b1;

    // Port 0 write 0xA5 to 0x1234
    drive(0, 1, 1, 16'h1234, 8'hA5);
    cycle();
    chk("wr.issue_ena", 32'(a_ena), 32'(1));
    chk("wr.issue_wea", 32'(a_wea), 32'(1));
    chk("wr.issue_addr", 32'(a_addr), 32'h1234);
    chk("wr.issue_din", 32'(a_din), 32'hA5);
    cycle();
    chk("wr.p0_ack_L3", 32'(a_p0_ack), 32'(1));
    chk("wr.p0_ack_L1", 32'(b_p0_ack), 32'(1));
    drive(0, 0, 0, 16'h0, 8'h0);
    cycle();

    // Port 1 read of 0xFFFC at both latencies
    drive(1, 1, 0, 16'hFFFC, 8'h0);
    cycle();
    cycle();
    chk("rd.p1_ack_L1", 32'(b_p1_ack), 32'(1));
    chk("rd.p1_rdata_L1", 32'(b_p1_rd), 32'h3C);
    chk("rd.p1_ack_L3_early", 32'(a_p1_ack), 32'(0));
    drive(1, 0, 0, 16'h0, 8'h0);
    cycle();
    chk("rd.p1_ack_L3_n3", 32'(a_p1_ack), 32'(0));
    cycle();
    chk("rd.p1_ack_L3", 32'(a_p1_ack), 32'(1));
    chk("rd.p1_rdata_L3", 32'(a_p1_rd), 32'h3C);
    cycle();

    // Both ports request continuously after reset
    reset_assert();
    reset_release();
    drive(0, 1, 1, 16'h0011, 8'h5A);
    drive(1, 1, 0, 16'h0012, 8'h00);
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (a_p0_ack) ord_a.push_back(0);
      if (a_p1_ack) ord_a.push_back(1);
      if (b_p0_ack) ord_b.push_back(0);
      if (b_p1_ack) ord_b.push_back(1);
    end
    drive(0, 0, 0, 16'h0, 8'h0);
    drive(1, 0, 0, 16'h0, 8'h0);
    chk("rr.count_L3", 32'(ord_a.size() >= 4), 32'(1));
    chk("rr.count_L1", 32'(ord_b.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++) begin
      if (i < ord_a.size()) chk($sformatf("rr.order_L3[%0d]", i), 32'(ord_a[i]), 32'(exp_ord[i]));
      if (i < ord_b.size()) chk($sformatf("rr.order_L1[%0d]", i), 32'(ord_b[i]), 32'(exp_ord[i]));
    end
    for (int i = 0; i < 6; i++) cycle();

    // Reset during WAIT of a port 0 read
    drive(0, 1, 0, 16'h0010, 8'h0);
    cycle();
    cycle();
    chk("rstwait.in_wait_busy", 32'(a_busy), 32'(1));
    drive(0, 0, 0, 16'h0, 8'h0);
    reset_assert();
    chk("rstwait.busy0", 32'(a_busy), 32'(0));
    chk("rstwait.ack0", 32'(a_p0_ack), 32'(0));
    chk("rstwait.addr0", 32'(a_addr), 32'(0));
    reset_release();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rstwait.no_ack", 32'(a_p0_ack), 32'(0));
    end
    drive(0, 1, 1, 16'h0042, 8'h77);
    cycle();
    cycle();
    chk("rstwait.next_ack", 32'(a_p0_ack), 32'(1));
    drive(0, 0, 0, 16'h0, 8'h0);
    cycle();

    // Reset before ISSUE: the write must never reach memory
    drive(1, 1, 1, 16'h0055, 8'hEE);
    reset_assert();
    drive(1, 0, 0, 16'h0, 8'h0);
    reset_release();
    cycle();
    drive(0, 1, 0, 16'h0055, 8'h0);
    cycle();
    cycle();
    drive(0, 0, 0, 16'h0, 8'h0);
    cycle();
    cycle();
    chk("rstissue.rdata_L3", 32'(a_p0_rd), 32'hF2);
    chk("rstissue.rdata_L1", 32'(b_p0_rd), 32'hF2);
    cycle();

    // Port 1 drops req right after grant
    drive(1, 1, 1, 16'h0020, 8'h99);
    cycle();
    drive(1, 0, 0, 16'h0, 8'h0);
    acks_a = 0;
    acks_b = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      acks_a += int'(a_p1_ack);
      acks_b += int'(b_p1_ack);
    end
    chk("drop.acks_L3", 32'(acks_a), 32'(1));
    chk("drop.acks_L1", 32'(acks_b), 32'(1));
    chk("drop.busy_L3", 32'(a_busy), 32'(0));
    chk("drop.busy_L1", 32'(b_busy), 32'(0));

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        logic [15:0] ad;
        case ($urandom_range(0, 4))
          0:       ad = 16'hFFFC;
          1:       ad = 16'h0010;
          2:       ad = 16'h0011;
          3:       ad = 16'h0012;
          default: ad = 16'h1234;
        endcase
        drive(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ad, 8'($urandom));
      end
      if ($urandom_range(0, 63) == 0) begin
        reset_assert();
        reset_release();
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
